// File: rtl/fan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fan_pkg
//  Description : Shared types, duty constants and ramp helpers for the fan
//                speed sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fan_pkg;

    // Controller state, derived each cycle from applied speed vs. target
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Temperature zone
    typedef enum logic [1:0] {
        Z_OFF  = 2'd0,
        Z_MID  = 2'd1,
        Z_FULL = 2'd2
    } zone_t;

    localparam logic [7:0] SPD_OFF     = 8'd0;
    localparam logic [7:0] SPD_MID     = 8'd128;
    localparam logic [7:0] SPD_FULL    = 8'd255;
    localparam logic [7:0] PERIOD_LAST = 8'd255;

    // Duty value associated with a zone
    function automatic logic [7:0] zone_speed(input zone_t z);
        logic [7:0] v;
        case (z)
            Z_MID:   v = SPD_MID;
            Z_FULL:  v = SPD_FULL;
            default: v = SPD_OFF;
        endcase
        return v;
    endfunction

    // One ramp step toward tgt, clamped so it never passes tgt, 0 or 255.
    // Done in 9 bits so the add/subtract cannot wrap before clamping.
    function automatic logic [7:0] ramp_step(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [8:0] w_sum;
        logic [8:0] w_dif;
        logic [7:0] v;
        w_sum = {1'b0, cur} + {1'b0, step};
        w_dif = {1'b0, cur} - {1'b0, step};
        if (cur < tgt) begin
            v = (w_sum > {1'b0, tgt}) ? tgt : w_sum[7:0];
        end else if (cur > tgt) begin
            // Borrow out of bit 8 means the subtraction went below zero
            if (w_dif[8] || (w_dif[7:0] < tgt)) begin
                v = tgt;
            end else begin
                v = w_dif[7:0];
            end
        end else begin
            v = cur;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fan_zone_detect.sv
`default_nettype none
// ============================================================================
//  Module      : fan_zone_detect
//  Description : Temperature zone register with hysteresis on downward moves.
//                Zone changes only on a qualified temperature sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module fan_zone_detect
    import fan_pkg::*;
#(
    parameter int unsigned T_LOW  = 25,
    parameter int unsigned T_HIGH = 35,
    parameter int unsigned HYST   = 2
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] i_temp,
    input  logic       i_temp_valid,
    output zone_t      o_zone
);

    localparam logic [7:0] c_low_up  = 8'(T_LOW);
    localparam logic [7:0] c_low_dn  = 8'(T_LOW - HYST);
    localparam logic [7:0] c_high_up = 8'(T_HIGH);
    localparam logic [7:0] c_high_dn = 8'(T_HIGH - HYST);

    logic  w_ge_low;
    logic  w_ge_high;
    logic  w_lt_low_dn;
    logic  w_lt_high_dn;
    zone_t r_zone;

    assign w_ge_low     = (i_temp >= c_low_up);
    assign w_ge_high    = (i_temp >= c_high_up);
    assign w_lt_low_dn  = (i_temp <  c_low_dn);
    assign w_lt_high_dn = (i_temp <  c_high_dn);

    // Zone transitions: upward on plain thresholds, downward on thresholds
    // lowered by the hysteresis band
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_zone <= Z_OFF;
        end else if (i_temp_valid) begin
            case (r_zone)
                Z_OFF: begin
                    if (w_ge_high)     r_zone <= Z_FULL;
                    else if (w_ge_low) r_zone <= Z_MID;
                end
                Z_MID: begin
                    if (w_ge_high)        r_zone <= Z_FULL;
                    else if (w_lt_low_dn) r_zone <= Z_OFF;
                end
                Z_FULL: begin
                    if (w_lt_low_dn)       r_zone <= Z_OFF;
                    else if (w_lt_high_dn) r_zone <= Z_MID;
                end
                default: r_zone <= Z_OFF;
            endcase
        end
    end

    assign o_zone = r_zone;

endmodule
`default_nettype wire

// File: rtl/fan_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fan_speed_ctrl
//  Description : Selects a duty target (temperature zone or manual request)
//                and ramps the applied PWM duty toward it in bounded steps,
//                changing it only at 256-cycle PWM period boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module fan_speed_ctrl
    import fan_pkg::*;
#(
    parameter int unsigned STEP   = 8,
    parameter int unsigned T_LOW  = 25,
    parameter int unsigned T_HIGH = 35,
    parameter int unsigned HYST   = 2
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] i_temp,
    input  logic       i_temp_valid,
    input  logic       i_auto_en,
    input  logic       i_man_req,
    input  logic [7:0] i_man_speed,
    output logic       o_man_ack,
    output logic [7:0] o_speed,
    output logic [7:0] o_target,
    output logic       o_ramping,
    output logic       o_period_start
);

    localparam logic [7:0] c_step = 8'(STEP);

    logic [7:0] r_cnt;
    logic       r_req_d;
    logic       r_take;
    logic       r_ack;
    logic [7:0] r_man_tgt;
    logic [7:0] r_target;
    logic [7:0] r_speed;
    state_t     r_state;
    zone_t      w_zone;
    logic       w_req_rise;

    fan_zone_detect #(
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH),
        .HYST   (HYST)
    ) u_zone (
        .clk          (clk),
        .arst         (arst),
        .i_temp       (i_temp),
        .i_temp_valid (i_temp_valid),
        .o_zone       (w_zone)
    );

    // Free-running PWM period counter
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // A held request counts once: only a low-to-high level is accepted
    assign w_req_rise = i_man_req & ~r_req_d;

    // Manual handshake: latch the request value, acknowledge one cycle later
    // so the ack lines up with the target register picking the value up
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_req_d   <= 1'b0;
            r_take    <= 1'b0;
            r_ack     <= 1'b0;
            r_man_tgt <= 8'd0;
        end else begin
            r_req_d <= i_man_req;
            r_take  <= w_req_rise;
            r_ack   <= r_take;
            if (w_req_rise) begin
                r_man_tgt <= i_man_speed;
            end
        end
    end

    // Target mux, registered; follows its source without waiting for a period
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_target <= 8'd0;
        end else begin
            r_target <= i_auto_en ? zone_speed(w_zone) : r_man_tgt;
        end
    end

    // Applied duty moves one step on the last cycle of each period only
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_speed <= 8'd0;
        end else if (r_cnt == PERIOD_LAST) begin
            r_speed <= ramp_step(r_speed, r_target, c_step);
        end
    end

    // Controller state from registered speed vs. target
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else if ((r_speed == 8'd0) && (r_target == 8'd0)) begin
            r_state <= IDLE;
        end else if (r_speed < r_target) begin
            r_state <= UP;
        end else if (r_speed > r_target) begin
            r_state <= DOWN;
        end else begin
            r_state <= HOLD;
        end
    end

    assign o_man_ack      = r_ack;
    assign o_speed        = r_speed;
    assign o_target       = r_target;
    assign o_ramping      = (r_state == UP) || (r_state == DOWN);
    assign o_period_start = (r_cnt == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_fan_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fan_speed_ctrl
//  Description : Self-checking bench for fan_speed_ctrl: directed sequences,
//                a zone table, and random stimulus against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fan_speed_ctrl;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] temp = 8'd0;
    logic       temp_valid = 1'b0;
    logic       auto_en = 1'b0;
    logic       man_req = 1'b0;
    logic [7:0] man_speed = 8'd0;

    logic       man_ack, ramping, period_start;
    logic [7:0] speed, target;
    logic       man_ack2, ramping2, period_start2;
    logic [7:0] speed2, target2;

    int n_tests = 0;
    int n_fail  = 0;

    fan_speed_ctrl dut (
        .clk            (clk),
        .arst           (arst),
        .i_temp         (temp),
        .i_temp_valid   (temp_valid),
        .i_auto_en      (auto_en),
        .i_man_req      (man_req),
        .i_man_speed    (man_speed),
        .o_man_ack      (man_ack),
        .o_speed        (speed),
        .o_target       (target),
        .o_ramping      (ramping),
        .o_period_start (period_start)
    );

    fan_speed_ctrl #(.STEP(100)) dut2 (
        .clk            (clk),
        .arst           (arst),
        .i_temp         (temp),
        .i_temp_valid   (temp_valid),
        .i_auto_en      (auto_en),
        .i_man_req      (man_req),
        .i_man_speed    (man_speed),
        .o_man_ack      (man_ack2),
        .o_speed        (speed2),
        .o_target       (target2),
        .o_ramping      (ramping2),
        .o_period_start (period_start2)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (STEP = 8 instance) -----------------
    int m_zone = 0, m_man = 0, m_tgt = 0, m_spd = 0, m_cnt = 0;
    int m_take = 0, m_ack = 0, m_ramp = 0, m_reqp = 0;

    function automatic int zone_duty(int z);
        return (z == 0) ? 0 : ((z == 1) ? 128 : 255);
    endfunction

    // Zone rules written directly from the temperature thresholds
    function automatic int zone_next(int z, int t);
        if (z == 0) return (t >= 35) ? 2 : ((t >= 25) ? 1 : 0);
        if (z == 1) return (t >= 35) ? 2 : ((t < 23) ? 0 : 1);
        return (t < 23) ? 0 : ((t < 33) ? 1 : 2);
    endfunction

    function automatic int move(int s, int t, int st);
        if (s < t) return (s + st > t) ? t : s + st;
        if (s > t) return (s - st < t) ? t : s - st;
        return s;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_zone = 0; m_man = 0; m_tgt = 0; m_spd = 0; m_cnt = 0;
            m_take = 0; m_ack = 0; m_ramp = 0; m_reqp = 0;
        end else begin
            m_ramp = (m_spd != m_tgt) ? 1 : 0;
            if (m_cnt == 255) m_spd = move(m_spd, m_tgt, 8);
            m_tgt  = auto_en ? zone_duty(m_zone) : m_man;
            m_ack  = m_take;
            m_take = (man_req && !m_reqp) ? 1 : 0;
            if (m_take == 1) m_man = int'(man_speed);
            m_reqp = man_req ? 1 : 0;
            if (temp_valid) m_zone = zone_next(m_zone, int'(temp));
            m_cnt  = (m_cnt + 1) % 256;
        end
    end

    // Continuous comparison against the model, just after each active edge
    always @(posedge clk) begin
        #1;
        n_tests++;
        if (int'(speed) != m_spd || int'(target) != m_tgt || int'(man_ack) != m_ack ||
            int'(ramping) != m_ramp || int'(period_start) != ((m_cnt == 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL model t=%0t spd %0d/%0d tgt %0d/%0d ack %0d/%0d ramp %0d/%0d ps %0d/%0d (got/exp)",
                     $time, speed, m_spd, target, m_tgt, man_ack, m_ack, ramping, m_ramp,
                     period_start, (m_cnt == 0) ? 1 : 0);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ps();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 400);
        if (!period_start) begin
            n_tests++;
            n_fail++;
            $display("FAIL ps_wait: got no period_start expected one within 400 cycles");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1; temp_valid = 1'b0; man_req = 1'b0; auto_en = 1'b0;
        temp = 8'd0; man_speed = 8'd0;
        tick(2);
        arst = 1'b0;
    endtask

    task automatic man_pulse(input logic [7:0] v);
        @(negedge clk);
        man_speed = v; man_req = 1'b1;
        @(negedge clk);
        man_req = 1'b0;
    endtask

    typedef struct {
        logic [7:0] t;
        logic [7:0] exp_tgt;
    } zvec_t;

    zvec_t zv[12];

    initial begin
        int acks;
        int k;
        zv[0]  = '{8'd30, 8'd128};
        zv[1]  = '{8'd24, 8'd128};
        zv[2]  = '{8'd22, 8'd0};
        zv[3]  = '{8'd24, 8'd0};
        zv[4]  = '{8'd25, 8'd128};
        zv[5]  = '{8'd40, 8'd255};
        zv[6]  = '{8'd34, 8'd255};
        zv[7]  = '{8'd32, 8'd128};
        zv[8]  = '{8'd36, 8'd255};
        zv[9]  = '{8'd10, 8'd0};
        zv[10] = '{8'd35, 8'd255};
        zv[11] = '{8'd22, 8'd0};

        // Reset state and manual ramp to 40
        do_reset();
        #1;
        check("rst_speed", speed, 0);
        check("rst_target", target, 0);
        check("rst_ack", man_ack, 0);
        check("rst_ramping", ramping, 0);
        check("rst_period_start", period_start, 1);
        @(negedge clk);
        man_speed = 8'd40; man_req = 1'b1;
        @(negedge clk);
        man_req = 1'b0;
        check("ack_not_yet", man_ack, 0);
        @(negedge clk);
        check("ack_pulse", man_ack, 1);
        check("man_target", target, 40);
        @(negedge clk);
        check("ack_drop", man_ack, 0);
        for (int i = 1; i <= 5; i++) begin
            wait_ps();
            check("ramp_up_speed", speed, 8 * i);
            if (i < 5) check("ramp_up_ramping", ramping, 1);
        end
        tick(3);
        check("hold_ramping", ramping, 0);
        check("hold_speed", speed, 40);

        // Zone table with hysteresis
        @(negedge clk);
        auto_en = 1'b1;
        foreach (zv[i]) begin
            temp = zv[i].t; temp_valid = 1'b1;
            @(negedge clk);
            temp_valid = 1'b0;
            @(negedge clk);
            check("zone_target", target, zv[i].exp_tgt);
            tick(3);
        end
        k = 0;
        while (speed != 8'd0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        tick(2);
        check("down_speed_zero", speed, 0);
        check("idle_ramping", ramping, 0);

        // Saturation at 255, both step sizes
        do_reset();
        @(negedge clk);
        auto_en = 1'b1; temp = 8'd40; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        @(negedge clk);
        check("full_target", target, 255);
        for (int i = 1; i <= 33; i++) begin
            wait_ps();
            if (i == 1)  check("sat_p1", speed, 8);
            if (i == 31) check("sat_p31", speed, 248);
            if (i == 32) check("sat_p32", speed, 255);
            if (i == 33) check("sat_nowrap", speed, 255);
            if (i == 1)  check("step100_p1", speed2, 100);
            if (i == 2)  check("step100_p2", speed2, 200);
            if (i == 3)  check("step100_p3", speed2, 255);
            if (i == 4)  check("step100_p4", speed2, 255);
        end

        // Reversal mid-ramp
        do_reset();
        man_pulse(8'd200);
        repeat (8) wait_ps();
        check("rev_at64", speed, 64);
        man_pulse(8'd48);
        wait_ps();
        check("rev_p1", speed, 56);
        wait_ps();
        check("rev_p2", speed, 48);
        tick(3);
        check("rev_hold_ramping", ramping, 0);
        check("rev_hold_speed", speed, 48);

        // Asynchronous reset mid-ramp
        do_reset();
        man_pulse(8'd200);
        repeat (12) wait_ps();
        check("pre_arst_speed", speed, 96);
        tick(50);
        arst = 1'b1;
        #1;
        check("arst_speed", speed, 0);
        check("arst_target", target, 0);
        check("arst_ack", man_ack, 0);
        check("arst_ramping", ramping, 0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("arst_rel_ps", period_start, 1);

        // Held request acknowledged once
        @(negedge clk);
        man_speed = 8'd77; man_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 9) man_req = 1'b0;
            if (man_ack) acks++;
        end
        check("held_req_acks", acks, 1);
        check("held_req_target", target, 77);

        // Random stimulus, checked by the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            temp_valid = ($urandom % 4) == 0;
            temp       = 8'($urandom_range(0, 60));
            if (($urandom % 200) == 0) auto_en = ~auto_en;
            man_req    = (($urandom % 30) == 0) ? 1'b1 : (man_req & (($urandom % 2) == 0));
            man_speed  = 8'($urandom);
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
